snake_grid_renderer: RTL and testbench

Parametrised snake engine and grid-cell colouriser for the VGA snake game. Holds a body of up to MAX_LEN segments in a register buffer, advances it one cell per game tick with growth, reversal lock and wall/self collision detection. For each queried grid cell it returns a registered 12-bit colour, distinguishing head, body and background. It sits between the frame-rate tick generator and the VGA pixel/colour driver, replacing the fixed four-segment colouriser.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_hit_cmp.sv | 29 ++
 rtl/snake_grid_renderer.sv | 127 ++++++++++++
 tb/tb_snake_grid_renderer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake engine and grid colouriser.
package snake_pkg;
    localparam int SEG_COORD_W = 6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [11:0] HEAD_COL = 12'h0A0;
    localparam logic [11:0] BODY_COL = 12'h0F0;
    localparam logic [11:0] BG_COL   = 12'hFFF;
    localparam logic [11:0] BLACK    = 12'h000;

    typedef struct packed {
        logic [SEG_COORD_W-1:0] x;
        logic [SEG_COORD_W-1:0] y;
    } seg_t;

    // Up/down and left/right differ only in bit 1.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction
endpackage

// File: rtl/snake_hit_cmp.sv
// Parallel compare of one grid point against every live segment of the body.
module snake_hit_cmp
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  seg_t [MAX_LEN-1:0] segs,
    input  seg_t               query,
    input  logic [LEN_W-1:0]   len,
    input  logic               excl_tail,
    output logic               head_match,
    output logic               body_any
);
    logic [LEN_W-1:0]   lim;
    logic [MAX_LEN-1:0] body_match;

    // A non-growing move vacates the tail, so it is not an obstacle.
    assign lim = excl_tail ? len - 1'b1 : len;

    always_comb begin
        body_match = '0;
        for (int i = 1; i < MAX_LEN; i++)
            body_match[i] = (segs[i] == query) && (LEN_W'(i) < lim);
    end

    assign head_match = (segs[0] == query);
    assign body_any   = |body_match;
endmodule

// File: rtl/snake_grid_renderer.sv
// Snake body engine (move, grow, collide) plus registered per-cell colour lookup.
module snake_grid_renderer
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int COORD_W  = 6,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step,
    input  logic                           grow,
    input  logic [1:0]                     dir,
    input  logic                           all_black,
    input  logic                           pix_valid,
    input  logic [COORD_W-1:0]             h_index,
    input  logic [COORD_W-1:0]             v_index,
    output logic [11:0]                    color,
    output logic                           color_valid,
    output logic [$clog2(MAX_LEN+1)-1:0]   len,
    output logic                           wall_hit,
    output logic                           self_hit
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]   MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [COORD_W:0]   GRID_W_C  = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0]   GRID_H_C  = (COORD_W+1)'(GRID_H);

    // The segment struct width is fixed in the package; the port width must agree.
    if (COORD_W != SEG_COORD_W) begin : g_width_check
        $error("COORD_W must equal snake_pkg::SEG_COORD_W");
    end

    seg_t [MAX_LEN-1:0] segs;
    logic [1:0]         last_dir;
    logic [1:0]         eff_dir;
    logic [COORD_W:0]   nx, ny;
    seg_t               next_head;
    seg_t               pix_pt;
    logic               dead, wall, grows;
    logic               self_head, self_body;
    logic               pix_head, pix_body, in_grid;
    logic [11:0]        next_color;

    assign dead    = wall_hit | self_hit;
    assign eff_dir = (dir == opposite(last_dir) && len > LEN_W'(1)) ? last_dir : dir;
    assign grows   = grow && (len < MAX_LEN_C);

    // One extra bit so x=0 moving left becomes a large value instead of wrapping in range.
    always_comb begin
        nx = {1'b0, segs[0].x};
        ny = {1'b0, segs[0].y};
        case (eff_dir)
            DIR_UP:    ny = ny - 1'b1;
            DIR_RIGHT: nx = nx + 1'b1;
            DIR_DOWN:  ny = ny + 1'b1;
            default:   nx = nx - 1'b1;
        endcase
    end

    assign wall      = (nx >= GRID_W_C) || (ny >= GRID_H_C);
    assign next_head = '{x: nx[COORD_W-1:0], y: ny[COORD_W-1:0]};
    assign pix_pt    = '{x: h_index, y: v_index};
    assign in_grid   = ({1'b0, h_index} < GRID_W_C) && ({1'b0, v_index} < GRID_H_C);

    snake_hit_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_self_cmp (
        .segs       (segs),
        .query      (next_head),
        .len        (len),
        .excl_tail  (!grows),
        .head_match (self_head),
        .body_any   (self_body)
    );

    snake_hit_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_pix_cmp (
        .segs       (segs),
        .query      (pix_pt),
        .len        (len),
        .excl_tail  (1'b0),
        .head_match (pix_head),
        .body_any   (pix_body)
    );

    always_comb begin
        next_color = BG_COL;
        if (all_black || !in_grid) next_color = BLACK;
        else if (pix_head)         next_color = HEAD_COL;
        else if (pix_body)         next_color = BODY_COL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    segs[i].x <= COORD_W'(GRID_W / 2 - i);
                    segs[i].y <= COORD_W'(GRID_H / 2);
                end else begin
                    segs[i] <= '0;
                end
            end
            len         <= LEN_W'(INIT_LEN);
            last_dir    <= DIR_RIGHT;
            wall_hit    <= 1'b0;
            self_hit    <= 1'b0;
            color       <= BLACK;
            color_valid <= 1'b0;
        end else begin
            if (step && !dead) begin
                if (wall) begin
                    wall_hit <= 1'b1;
                end else if (self_head || self_body) begin
                    self_hit <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++)
                        segs[i] <= segs[i-1];
                    segs[0]  <= next_head;
                    last_dir <= eff_dir;
                    if (grows) len <= len + 1'b1;
                end
            end
            if (pix_valid) color <= next_color;
            color_valid <= pix_valid;
        end
    end
endmodule

// File: tb/tb_snake_grid_renderer.sv
// Scenario tests plus randomized play against a behavioural snake model.
module tb_snake_grid_renderer;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 4;
    localparam int COORD_W  = 6;
    localparam int GRID_W   = 40;
    localparam int GRID_H   = 30;

    logic              clk = 1'b0;
    logic              rst, step, grow, all_black, pix_valid;
    logic [1:0]        dir;
    logic [COORD_W-1:0] h_index, v_index;
    logic [11:0]       color;
    logic              color_valid;
    logic [4:0]        len;
    logic              wall_hit, self_hit;

    int errors = 0;
    int checks = 0;

    int mx[MAX_LEN];
    int my[MAX_LEN];
    int m_len, m_last;
    bit m_wall, m_self;

    snake_grid_renderer #(
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .COORD_W(COORD_W),
        .GRID_W(GRID_W), .GRID_H(GRID_H)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .grow(grow), .dir(dir),
        .all_black(all_black), .pix_valid(pix_valid),
        .h_index(h_index), .v_index(v_index),
        .color(color), .color_valid(color_valid), .len(len),
        .wall_hit(wall_hit), .self_hit(self_hit)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < MAX_LEN; i++) begin
            mx[i] = (i < INIT_LEN) ? GRID_W / 2 - i : 0;
            my[i] = (i < INIT_LEN) ? GRID_H / 2 : 0;
        end
        m_len = INIT_LEN; m_last = 1; m_wall = 0; m_self = 0;
    endfunction

    function automatic void m_step(input int d, input bit g);
        int eff, nx, ny, lim;
        bit grows;
        if (m_wall || m_self) return;
        eff = (m_len > 1 && d == (m_last + 2) % 4) ? m_last : d;
        nx = mx[0]; ny = my[0];
        case (eff)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            m_wall = 1;
            return;
        end
        grows = g && (m_len < MAX_LEN);
        lim = grows ? m_len : m_len - 1;
        for (int i = 0; i < lim; i++)
            if (mx[i] == nx && my[i] == ny) begin
                m_self = 1;
                return;
            end
        for (int i = MAX_LEN - 1; i > 0; i--) begin
            mx[i] = mx[i-1]; my[i] = my[i-1];
        end
        mx[0] = nx; my[0] = ny; m_last = eff;
        if (grows) m_len = m_len + 1;
    endfunction

    function automatic logic [11:0] m_color(input int h, input int v, input bit blk);
        if (blk) return 12'h000;
        if (h >= GRID_W || v >= GRID_H) return 12'h000;
        if (h == mx[0] && v == my[0]) return 12'h0A0;
        for (int i = 1; i < m_len; i++)
            if (h == mx[i] && v == my[i]) return 12'h0F0;
        return 12'hFFF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; step = 0; grow = 0; pix_valid = 0; all_black = 0; dir = 2'd1;
        h_index = '0; v_index = '0;
        @(negedge clk);
        rst = 0;
        m_reset();
    endtask

    task automatic do_step(input int d, input bit g);
        @(negedge clk);
        step = 1; dir = 2'(d); grow = g;
        m_step(d, g);
        @(negedge clk);
        step = 0; grow = 0;
    endtask

    task automatic query(input int h, input int v, output logic [11:0] c, output logic cv);
        @(negedge clk);
        pix_valid = 1; h_index = COORD_W'(h); v_index = COORD_W'(v);
        @(negedge clk);
        c = color; cv = color_valid;
        pix_valid = 0;
    endtask

    task automatic test_reset();
        logic [11:0] c; logic cv;
        int qh[4] = '{20, 19, 17, 16};
        do_reset();
        checks++; if (len !== 5'd4) begin errors++; $display("FAIL reset_len: got %0d expected 4", len); end
        checks++; if (wall_hit !== 1'b0 || self_hit !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", wall_hit, self_hit); end
        checks++; if (color !== 12'h000 || color_valid !== 1'b0) begin errors++; $display("FAIL reset_color: got %h/%b expected 000/0", color, color_valid); end
        foreach (qh[k]) begin
            query(qh[k], 15, c, cv);
            checks++; if (c !== m_color(qh[k], 15, 0) || cv !== 1'b1) begin errors++; $display("FAIL reset_query(%0d,15): got %h/%b expected %h/1", qh[k], c, cv, m_color(qh[k], 15, 0)); end
        end
    endtask

    task automatic test_move();
        logic [11:0] c; logic cv;
        int qh[3] = '{23, 20, 19};
        for (int k = 0; k < 3; k++) do_step(1, 0);
        foreach (qh[k]) begin
            query(qh[k], 15, c, cv);
            checks++; if (c !== m_color(qh[k], 15, 0)) begin errors++; $display("FAIL move_query(%0d,15): got %h expected %h", qh[k], c, m_color(qh[k], 15, 0)); end
        end
    endtask

    task automatic test_reversal();
        logic [11:0] c; logic cv;
        do_step(3, 0);
        query(24, 15, c, cv);
        checks++; if (c !== m_color(24, 15, 0)) begin errors++; $display("FAIL reversal_head: got %h expected %h", c, m_color(24, 15, 0)); end
        do_step(3, 0);
        query(25, 15, c, cv);
        checks++; if (c !== m_color(25, 15, 0)) begin errors++; $display("FAIL reversal_lastdir: got %h expected %h", c, m_color(25, 15, 0)); end
    endtask

    task automatic test_grow_saturate();
        logic [11:0] c; logic cv;
        for (int k = 0; k < 13; k++) begin
            do_step(1, 1);
            checks++; if (len !== 5'(m_len)) begin errors++; $display("FAIL grow_len[%0d]: got %0d expected %0d", k, len, m_len); end
        end
        checks++; if (len !== 5'd16) begin errors++; $display("FAIL grow_sat: got %0d expected 16", len); end
        query(mx[0], my[0], c, cv);
        checks++; if (c !== 12'h0A0) begin errors++; $display("FAIL grow_last_move: got %h expected 0a0", c); end
    endtask

    task automatic test_wall();
        logic [11:0] c; logic cv;
        while (mx[0] < GRID_W - 1) do_step(1, 0);
        checks++; if (wall_hit !== 1'b0) begin errors++; $display("FAIL wall_early: got %b expected 0", wall_hit); end
        do_step(1, 0);
        checks++; if (wall_hit !== m_wall) begin errors++; $display("FAIL wall_hit: got %b expected %b", wall_hit, m_wall); end
        query(GRID_W - 1, 15, c, cv);
        checks++; if (c !== m_color(GRID_W - 1, 15, 0)) begin errors++; $display("FAIL wall_head: got %h expected %h", c, m_color(GRID_W - 1, 15, 0)); end
        do_step(2, 1);
        query(GRID_W - 1, 16, c, cv);
        checks++; if (c !== m_color(GRID_W - 1, 16, 0) || len !== 5'(m_len)) begin errors++; $display("FAIL wall_dead_step: got %h/%0d expected %h/%0d", c, len, m_color(GRID_W - 1, 16, 0), m_len); end
        do_reset();
        checks++; if (wall_hit !== 1'b0) begin errors++; $display("FAIL wall_clear: got %b expected 0", wall_hit); end
    endtask

    task automatic test_self();
        logic [11:0] c; logic cv;
        do_reset();
        do_step(1, 1);
        checks++; if (len !== 5'd5) begin errors++; $display("FAIL self_len: got %0d expected 5", len); end
        do_step(0, 0); do_step(3, 0);
        checks++; if (self_hit !== 1'b0) begin errors++; $display("FAIL self_early: got %b expected 0", self_hit); end
        do_step(2, 0);
        checks++; if (self_hit !== m_self || m_self !== 1'b1) begin errors++; $display("FAIL self_hit: got %b expected 1", self_hit); end
        query(20, 14, c, cv);
        checks++; if (c !== m_color(20, 14, 0)) begin errors++; $display("FAIL self_head: got %h expected %h", c, m_color(20, 14, 0)); end
    endtask

    task automatic test_chase_tail();
        logic [11:0] c; logic cv;
        do_reset();
        do_step(0, 0); do_step(3, 0); do_step(2, 0);
        checks++; if (self_hit !== 1'b0 || m_self) begin errors++; $display("FAIL chase_tail: got %b expected 0", self_hit); end
        query(19, 15, c, cv);
        checks++; if (c !== m_color(19, 15, 0)) begin errors++; $display("FAIL chase_head: got %h expected %h", c, m_color(19, 15, 0)); end
    endtask

    task automatic test_all_black();
        logic [11:0] c; logic cv;
        int qh[3] = '{mx[0], mx[1], 5};
        int qv[3] = '{my[0], my[1], 5};
        all_black = 1;
        foreach (qh[k]) begin
            query(qh[k], qv[k], c, cv);
            checks++; if (c !== 12'h000) begin errors++; $display("FAIL all_black(%0d,%0d): got %h expected 000", qh[k], qv[k], c); end
        end
        all_black = 0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] c, exp_c; logic cv;
        do_reset();
        @(negedge clk); step = 1; dir = 2'd1; m_step(1, 0);
        @(negedge clk); dir = 2'd2; m_step(2, 0);
        @(negedge clk); dir = 2'd2; m_step(2, 0);
        @(negedge clk); step = 0;
        query(mx[0], my[0], c, cv);
        checks++; if (c !== 12'h0A0 || mx[0] != 21 || my[0] != 17) begin errors++; $display("FAIL b2b_head: got %h expected 0a0 at (21,17)", c); end
        // Query the head in the same cycle as a step: render sees the pre-step body.
        @(negedge clk);
        step = 1; dir = 2'd1; pix_valid = 1; h_index = COORD_W'(mx[0]); v_index = COORD_W'(my[0]);
        exp_c = m_color(mx[0], my[0], 0);
        m_step(1, 0);
        @(negedge clk);
        step = 0; pix_valid = 0;
        checks++; if (color !== exp_c) begin errors++; $display("FAIL step_and_query: got %h expected %h", color, exp_c); end
    endtask

    task automatic test_mid_reset();
        do_step(1, 1);
        @(negedge clk);
        rst = 1; pix_valid = 1; h_index = COORD_W'(mx[0]); v_index = COORD_W'(my[0]);
        @(negedge clk);
        rst = 0; pix_valid = 0; m_reset();
        checks++; if (color_valid !== 1'b0 || color !== 12'h000 || len !== 5'd4) begin errors++; $display("FAIL mid_reset: got %b/%h/%0d expected 0/000/4", color_valid, color, len); end
    endtask

    task automatic test_random();
        logic [11:0] exp_col;
        bit exp_cv, pending, st, gr, pv, ab;
        int d, h, v;
        do_reset();
        exp_col = 12'h000; exp_cv = 0; pending = 0;
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            if (pending) begin
                checks++;
                if (color !== exp_col || color_valid !== exp_cv || len !== 5'(m_len) ||
                    wall_hit !== m_wall || self_hit !== m_self) begin
                    errors++;
                    $display("FAIL random[%0d]: got col=%h v=%b len=%0d w=%b s=%b expected col=%h v=%b len=%0d w=%b s=%b",
                             it, color, color_valid, len, wall_hit, self_hit, exp_col, exp_cv, m_len, m_wall, m_self);
                end
            end
            if ((m_wall || m_self) && $urandom_range(0, 3) == 0) begin
                rst = 1; step = 0; pix_valid = 0;
                m_reset(); exp_col = 12'h000; exp_cv = 0; pending = 1;
                continue;
            end
            rst = 0;
            st = ($urandom_range(0, 2) != 0);
            gr = ($urandom_range(0, 3) == 0);
            d  = $urandom_range(0, 3);
            pv = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                h = mx[0] + $urandom_range(0, 4) - 2; if (h < 0) h = 0;
                v = my[0] + $urandom_range(0, 4) - 2; if (v < 0) v = 0;
            end else begin
                h = $urandom_range(0, 63); v = $urandom_range(0, 63);
            end
            step = st; grow = gr; dir = 2'(d); pix_valid = pv; all_black = ab;
            h_index = COORD_W'(h); v_index = COORD_W'(v);
            if (pv) exp_col = m_color(h, v, ab);
            exp_cv = pv;
            if (st) m_step(d, gr);
            pending = 1;
        end
        @(negedge clk);
        checks++;
        if (color !== exp_col || color_valid !== exp_cv || len !== 5'(m_len)) begin
            errors++;
            $display("FAIL random_last: got %h/%b/%0d expected %h/%b/%0d", color, color_valid, len, exp_col, exp_cv, m_len);
        end
        rst = 0; step = 0; grow = 0; pix_valid = 0; all_black = 0;
    endtask

    initial begin
        rst = 1; step = 0; grow = 0; dir = 2'd1; all_black = 0; pix_valid = 0;
        h_index = '0; v_index = '0;
        m_reset();
        test_reset();
        test_move();
        test_reversal();
        test_grow_saturate();
        test_wall();
        test_self();
        test_chase_tail();
        test_all_black();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
